// File: rtl/wrr_out_sched.sv
// rtl/wrr_out_sched.sv - four-port packet-granular weighted round-robin egress scheduler; optional packet counters under WRR_STAT_EN
module wrr_out_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int WGT_WIDTH  = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [DATA_WIDTH-1:0] iData0,
    input  logic [DATA_WIDTH-1:0] iData1,
    input  logic [DATA_WIDTH-1:0] iData2,
    input  logic [DATA_WIDTH-1:0] iData3,
    input  logic                  iVld0,
    input  logic                  iVld1,
    input  logic                  iVld2,
    input  logic                  iVld3,
    input  logic                  iLast0,
    input  logic                  iLast1,
    input  logic                  iLast2,
    input  logic                  iLast3,
    output logic                  oRdy0,
    output logic                  oRdy1,
    output logic                  oRdy2,
    output logic                  oRdy3,
    input  logic [WGT_WIDTH-1:0]  iWeight0,
    input  logic [WGT_WIDTH-1:0]  iWeight1,
    input  logic [WGT_WIDTH-1:0]  iWeight2,
    input  logic [WGT_WIDTH-1:0]  iWeight3,
    output logic [DATA_WIDTH-1:0] oData,
    output logic                  oVld,
    output logic                  oLast,
`ifdef WRR_STAT_EN
    output logic [15:0]           oPktCnt0,
    output logic [15:0]           oPktCnt1,
    output logic [15:0]           oPktCnt2,
    output logic [15:0]           oPktCnt3,
`endif
    input  logic                  iRdy,
    output logic [3:0]            oGrant,
    output logic                  oBusy
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] data_a [4];
    logic [WGT_WIDTH-1:0]  wgt_a  [4];
    logic [3:0]            vld_a;
    logic [3:0]            last_a;
    logic [3:0]            rdy_a;

    state_t               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [WGT_WIDTH-1:0] credit_q, credit_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [3:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;

    logic                 sel_hit;
    logic                 sel_load;
    logic [1:0]           sel_port;
    logic                 eop_hs;

    assign data_a[0] = iData0;
    assign data_a[1] = iData1;
    assign data_a[2] = iData2;
    assign data_a[3] = iData3;
    assign wgt_a[0]  = iWeight0;
    assign wgt_a[1]  = iWeight1;
    assign wgt_a[2]  = iWeight2;
    assign wgt_a[3]  = iWeight3;
    assign vld_a     = {iVld3, iVld2, iVld1, iVld0};
    assign last_a    = {iLast3, iLast2, iLast1, iLast0};

    // Candidate selection: keep the current port while it has credit, else search onward from rPtr+1
    always_comb begin
        logic [1:0] idx;
        sel_hit  = 1'b0;
        sel_load = 1'b0;
        sel_port = ptr_q;
        idx      = ptr_q;
        if (vld_a[ptr_q] && (credit_q != '0)) begin
            sel_hit = 1'b1;
        end else begin
            for (int i = 1; i <= 4; i++) begin
                idx = ptr_q + 2'(i);
                if (!sel_hit && vld_a[idx] && (wgt_a[idx] != '0)) begin
                    sel_hit  = 1'b1;
                    sel_load = 1'b1;
                    sel_port = idx;
                end
            end
        end
    end

    // Egress pass-through of the granted port; ready is steered from iRdy only, never from any iVld
    always_comb begin
        oData = '0;
        oVld  = 1'b0;
        oLast = 1'b0;
        rdy_a = 4'b0000;
        if (state_q == XFER) begin
            oData        = data_a[gnt_q];
            oVld         = vld_a[gnt_q];
            oLast        = last_a[gnt_q];
            rdy_a[gnt_q] = iRdy;
        end
    end

    assign eop_hs = oVld & iRdy & oLast;
    assign oRdy0  = rdy_a[0];
    assign oRdy1  = rdy_a[1];
    assign oRdy2  = rdy_a[2];
    assign oRdy3  = rdy_a[3];
    assign oGrant = grant_q;
    assign oBusy  = busy_q;

    // Next-state: grant on a hit in IDLE, release and spend one credit on the accepted last beat
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        gnt_d    = gnt_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (sel_hit) begin
                    state_d = XFER;
                    gnt_d   = sel_port;
                    ptr_d   = sel_port;
                    grant_d = 4'b0001 << sel_port;
                    busy_d  = 1'b1;
                    if (sel_load) begin
                        credit_d = wgt_a[sel_port];
                    end
                end
            end
            XFER: begin
                if (eop_hs) begin
                    state_d  = IDLE;
                    grant_d  = 4'b0000;
                    busy_d   = 1'b0;
                    credit_d = (credit_q != '0) ? credit_q - 1'b1 : '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scheduler state registers; rPtr resets to 3 so the first search starts at port 0
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd3;
            credit_q <= '0;
            gnt_q    <= 2'd0;
            grant_q  <= 4'b0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

`ifdef WRR_STAT_EN
    logic [15:0] pkt_cnt_q [4];
    logic [15:0] pkt_cnt_d [4];

    // Per-port count of packets completed on egress, wrapping at 16 bits
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
        end
        if (eop_hs) begin
            pkt_cnt_d[gnt_q] = pkt_cnt_q[gnt_q] + 16'd1;
        end
    end

    // Packet counter registers
    always_ff @(posedge iClk) begin
        for (int i = 0; i < 4; i++) begin
            if (iRst) begin
                pkt_cnt_q[i] <= '0;
            end else begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    assign oPktCnt0 = pkt_cnt_q[0];
    assign oPktCnt1 = pkt_cnt_q[1];
    assign oPktCnt2 = pkt_cnt_q[2];
    assign oPktCnt3 = pkt_cnt_q[3];
`endif

endmodule

// File: tb/tb_wrr_out_sched.sv
// tb/tb_wrr_out_sched.sv - directed bench for wrr_out_sched
module tb_wrr_out_sched;
    localparam int DW = 32;
    localparam int WW = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic [DW-1:0] d_in [4];
    logic          vld_in [4];
    logic          last_in [4];
    logic [WW-1:0] wgt [4];
    logic          oRdy0, oRdy1, oRdy2, oRdy3;
    logic [DW-1:0] oData;
    logic          oVld, oLast, iRdy, oBusy;
    logic [3:0]    oGrant;
    logic [3:0]    rdy_v;
`ifdef WRR_STAT_EN
    logic [15:0]   oPktCnt0, oPktCnt1, oPktCnt2, oPktCnt3;
`endif

    int n_chk = 0;
    int n_fail = 0;

    int src_left [4];
    int src_len  [4];
    int src_beat [4];
    int src_pkt  [4];
    logic bubble = 1'b0;
    logic rdy_rand = 1'b0;

    logic          s_vld, s_last, s_busy, s_hs, s_irdy;
    logic [DW-1:0] s_data;
    logic [3:0]    s_grant, s_rdy;
    int            s_up;
    int            s_cyc;
    int            cyc = 0;

    always #5 iClk = ~iClk;
    assign rdy_v = {oRdy3, oRdy2, oRdy1, oRdy0};

    wrr_out_sched #(.DATA_WIDTH(DW), .WGT_WIDTH(WW)) dut (
        .iClk(iClk), .iRst(iRst),
        .iData0(d_in[0]), .iData1(d_in[1]), .iData2(d_in[2]), .iData3(d_in[3]),
        .iVld0(vld_in[0]), .iVld1(vld_in[1]), .iVld2(vld_in[2]), .iVld3(vld_in[3]),
        .iLast0(last_in[0]), .iLast1(last_in[1]), .iLast2(last_in[2]), .iLast3(last_in[3]),
        .oRdy0(oRdy0), .oRdy1(oRdy1), .oRdy2(oRdy2), .oRdy3(oRdy3),
        .iWeight0(wgt[0]), .iWeight1(wgt[1]), .iWeight2(wgt[2]), .iWeight3(wgt[3]),
        .oData(oData), .oVld(oVld), .oLast(oLast),
`ifdef WRR_STAT_EN
        .oPktCnt0(oPktCnt0), .oPktCnt1(oPktCnt1), .oPktCnt2(oPktCnt2), .oPktCnt3(oPktCnt3),
`endif
        .iRdy(iRdy), .oGrant(oGrant), .oBusy(oBusy)
    );

    function automatic logic [31:0] exp_data(int p, int pk, int bt);
        return 32'((p << 24) | (pk << 16) | bt);
    endfunction

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            logic gap;
            gap        = bubble && ($urandom_range(0, 2) == 0);
            vld_in[p]  = (src_left[p] > 0) && !gap;
            d_in[p]    = exp_data(p, src_pkt[p], src_beat[p]);
            last_in[p] = (src_beat[p] == src_len[p] - 1);
        end
    endtask

    task automatic clear_src();
        for (int p = 0; p < 4; p++) begin
            src_left[p] = 0;
            src_beat[p] = 0;
            src_pkt[p]  = 0;
            src_len[p]  = 2;
        end
    endtask

    task automatic tick();
        @(negedge iClk);
        s_vld   = oVld;
        s_last  = oLast;
        s_data  = oData;
        s_grant = oGrant;
        s_busy  = oBusy;
        s_rdy   = rdy_v;
        s_irdy  = iRdy;
        s_hs    = oVld && iRdy;
        s_cyc   = cyc;
        s_up    = -1;
        for (int p = 0; p < 4; p++) begin
            if (rdy_v[p] && vld_in[p]) s_up = p;
        end
        @(posedge iClk);
        #1;
        if (s_up >= 0) begin
            if (last_in[s_up]) begin
                src_beat[s_up] = 0;
                src_pkt[s_up]  = src_pkt[s_up] + 1;
                src_left[s_up] = src_left[s_up] - 1;
            end else begin
                src_beat[s_up] = src_beat[s_up] + 1;
            end
        end
        if (rdy_rand) iRdy = 1'($urandom_range(0, 1));
        drive();
        cyc = cyc + 1;
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        iRdy = 1'b1;
        bubble = 1'b0;
        rdy_rand = 1'b0;
        clear_src();
        drive();
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        for (int p = 0; p < 4; p++) wgt[p] = 4'd1;
        do_reset();
        tick();
        n_chk++; if (s_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", s_vld); end
        n_chk++; if (s_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", s_last); end
        n_chk++; if (s_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", s_data); end
        n_chk++; if (s_grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", s_grant); end
        n_chk++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", s_busy); end
        n_chk++; if (s_rdy !== 4'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0000", s_rdy); end
    endtask

    task automatic test_rr_equal();
        int pk = 0, bt = 0, cnt = 0, ep;
        do_reset();
        for (int p = 0; p < 4; p++) begin wgt[p] = 4'd1; src_left[p] = 100; end
        drive();
        while (pk < 8 && cnt < 100) begin
            tick(); cnt++;
            if (s_hs) begin
                ep = pk % 4;
                n_chk++; if (s_grant !== (4'b0001 << ep)) begin n_fail++; $display("FAIL rr_grant pkt %0d got %b exp port %0d", pk, s_grant, ep); end
                n_chk++; if (s_data !== exp_data(ep, pk / 4, bt)) begin n_fail++; $display("FAIL rr_data pkt %0d beat %0d got %h exp %h", pk, bt, s_data, exp_data(ep, pk / 4, bt)); end
                if (bt == 0) begin
                    n_chk++; if (s_cyc !== 1 + 3 * pk) begin n_fail++; $display("FAIL rr_timing pkt %0d first beat cycle %0d exp %0d", pk, s_cyc, 1 + 3 * pk); end
                end
                if (s_last) begin pk++; bt = 0; end else bt++;
            end
        end
        n_chk++; if (pk !== 8) begin n_fail++; $display("FAIL rr_timeout packets %0d exp 8", pk); end
    endtask

    task automatic test_weighted();
        int pk = 0, bt = 0, cnt = 0, ep;
        int exp_pk [4];
        int order [4] = '{0, 0, 0, 1};
        logic bad = 1'b0;
        do_reset();
        wgt[0] = 4'd3; wgt[1] = 4'd1; wgt[2] = 4'd0; wgt[3] = 4'd0;
        for (int p = 0; p < 4; p++) begin src_left[p] = 100; exp_pk[p] = 0; end
        drive();
        while (pk < 8 && cnt < 100) begin
            tick(); cnt++;
            if (s_rdy[2] || s_rdy[3]) bad = 1'b1;
            if (s_hs) begin
                ep = order[pk % 4];
                n_chk++; if (s_grant !== (4'b0001 << ep)) begin n_fail++; $display("FAIL wrr_grant pkt %0d got %b exp port %0d", pk, s_grant, ep); end
                n_chk++; if (s_data !== exp_data(ep, exp_pk[ep], bt)) begin n_fail++; $display("FAIL wrr_data pkt %0d got %h exp %h", pk, s_data, exp_data(ep, exp_pk[ep], bt)); end
                if (s_last) begin pk++; bt = 0; exp_pk[ep]++; end else bt++;
            end
        end
        n_chk++; if (pk !== 8) begin n_fail++; $display("FAIL wrr_timeout packets %0d exp 8", pk); end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL wrr_rdy23 got asserted exp never"); end
    endtask

    task automatic test_single_port();
        int pk = 0, bt = 0, cnt = 0;
        do_reset();
        wgt[0] = 4'd1; wgt[1] = 4'd1; wgt[2] = 4'd2; wgt[3] = 4'd1;
        src_left[2] = 4;
        drive();
        while (pk < 4 && cnt < 60) begin
            tick(); cnt++;
            if (s_hs) begin
                n_chk++; if (s_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant pkt %0d got %b exp 0100", pk, s_grant); end
                n_chk++; if (s_data !== exp_data(2, pk, bt)) begin n_fail++; $display("FAIL single_data pkt %0d got %h exp %h", pk, s_data, exp_data(2, pk, bt)); end
                if (bt == 0) begin
                    n_chk++; if (s_cyc !== 1 + 3 * pk) begin n_fail++; $display("FAIL single_timing pkt %0d cycle %0d exp %0d", pk, s_cyc, 1 + 3 * pk); end
                end
                if (s_last) begin pk++; bt = 0; end else bt++;
            end
        end
        n_chk++; if (pk !== 4) begin n_fail++; $display("FAIL single_timeout packets %0d exp 4", pk); end
    endtask

    task automatic test_bubbles();
        int bt = 0, cnt = 0;
        logic done = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) wgt[p] = 4'd1;
        src_len[0] = 16; src_left[0] = 1;
        bubble = 1'b1; rdy_rand = 1'b1;
        iRdy = 1'($urandom_range(0, 1));
        drive();
        while (!done && cnt < 600) begin
            tick(); cnt++;
            if (s_busy) begin
                n_chk++; if (s_rdy !== {3'b000, s_irdy}) begin n_fail++; $display("FAIL bubble_rdy got %b exp %b", s_rdy, {3'b000, s_irdy}); end
            end
            if (s_hs) begin
                n_chk++; if (s_data !== exp_data(0, 0, bt)) begin n_fail++; $display("FAIL bubble_data beat %0d got %h exp %h", bt, s_data, exp_data(0, 0, bt)); end
                n_chk++; if (s_last !== (bt == 15)) begin n_fail++; $display("FAIL bubble_last beat %0d got %b exp %b", bt, s_last, bt == 15); end
                if (s_last) done = 1'b1; else bt++;
            end
        end
        n_chk++; if (!done || bt !== 15) begin n_fail++; $display("FAIL bubble_timeout beats %0d exp 16", bt + 1); end
        bubble = 1'b0; rdy_rand = 1'b0; iRdy = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        int acc = 0, cnt = 0;
        logic bad_last = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) wgt[p] = 4'd1;
        src_len[1] = 10; src_left[1] = 1;
        drive();
        while (acc < 4 && cnt < 50) begin
            tick(); cnt++;
            if (s_up == 1) acc++;
            if (s_hs && s_last) bad_last = 1'b1;
        end
        n_chk++; if (acc !== 4) begin n_fail++; $display("FAIL rstmid_timeout beats %0d exp 4", acc); end
        iRst = 1'b1;
        tick();
        if (s_hs && s_last) bad_last = 1'b1;
        iRst = 1'b0;
        clear_src();
        drive();
        tick();
        n_chk++; if (s_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_vld got %b exp 0", s_vld); end
        n_chk++; if (s_grant !== 4'b0) begin n_fail++; $display("FAIL rstmid_grant got %b exp 0000", s_grant); end
        n_chk++; if (s_rdy !== 4'b0) begin n_fail++; $display("FAIL rstmid_rdy got %b exp 0000", s_rdy); end
        n_chk++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", s_busy); end
        n_chk++; if (bad_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_last got last beat exp none"); end
        src_left[0] = 1; src_left[1] = 1;
        drive();
        cnt = 0;
        s_hs = 1'b0;
        while (!s_hs && cnt < 20) begin tick(); cnt++; end
        n_chk++; if (s_grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant got %b exp 0001", s_grant); end
        n_chk++; if (s_data !== exp_data(0, 0, 0)) begin n_fail++; $display("FAIL rstmid_first_data got %h exp %h", s_data, exp_data(0, 0, 0)); end
    endtask

    task automatic test_zero_weights();
        logic bad = 1'b0;
        do_reset();
        for (int p = 0; p < 4; p++) begin wgt[p] = 4'd0; src_left[p] = 10; end
        drive();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_rdy !== 4'b0 || s_grant !== 4'b0 || s_vld !== 1'b0 || s_busy !== 1'b0) bad = 1'b1;
        end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL zero_wgt got activity exp none (last rdy %b grant %b)", s_rdy, s_grant); end
    endtask

`ifdef WRR_STAT_EN
    task automatic test_stats();
        int pk = 0, cnt = 0;
        do_reset();
        n_chk++; if (oPktCnt1 !== 16'd0) begin n_fail++; $display("FAIL stat_reset got %0d exp 0", oPktCnt1); end
        for (int p = 0; p < 4; p++) wgt[p] = 4'd1;
        src_len[1] = 1; src_left[1] = 10;
        drive();
        while (pk < 10 && cnt < 100) begin
            tick(); cnt++;
            if (s_hs && s_last) pk++;
        end
        tick();
        n_chk++; if (oPktCnt1 !== 16'd10) begin n_fail++; $display("FAIL stat_cnt1 got %0d exp 10", oPktCnt1); end
        n_chk++; if ({oPktCnt0, oPktCnt2, oPktCnt3} !== 48'd0) begin n_fail++; $display("FAIL stat_others got %0d %0d %0d exp 0", oPktCnt0, oPktCnt2, oPktCnt3); end
    endtask
`endif

    initial begin
        iRst = 1'b1;
        iRdy = 1'b1;
        for (int p = 0; p < 4; p++) wgt[p] = 4'd0;
        clear_src();
        drive();
        test_reset();
        test_rr_equal();
        test_weighted();
        test_single_port();
        test_bubbles();
        test_reset_mid_packet();
        test_zero_weights();
`ifdef WRR_STAT_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
